// File: rtl/if_id_queue_pkg.sv
`default_nettype none
// ============================================================================
// Module      : if_id_queue_pkg
// Description : Shared pipeline definitions for the IF/ID boundary.
//               XLEN      - width of pc and instruction fields
//               c_nop_instr - canonical bubble (addi x0, x0, 0)
//               fetch_entry_t - {pc, pc_plus4, instr} as carried IF -> ID;
//               the ID stage uses the same typedef.
// Revision    : 1.0 - initial release
// ============================================================================
package if_id_queue_pkg;

    localparam int XLEN = 32;

    localparam logic [31:0] c_nop_instr = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc_plus4;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

endpackage : if_id_queue_pkg
`default_nettype wire

// File: rtl/if_id_queue.sv
`default_nettype none
// ============================================================================
// Module      : if_id_queue
// Description : In-order instruction queue between IF and ID. Holds up to
//               DEPTH fetched entries and presents the head to ID over a
//               valid/ready handshake. flush empties the queue in one cycle.
// Ports       : clk, rst (sync, active-low)
//               flush                          - redirect, discards all entries
//               in_valid/in_ready, in_pc, in_pc_plus4, in_instr - from IF
//               stall_if                       - = ~in_ready, to IF
//               out_valid/out_ready, out_pc, out_pc_plus4, out_instr - to ID
//               count                          - current occupancy
// Revision    : 1.0 - initial release
// ============================================================================
module if_id_queue
    import if_id_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int XLEN  = if_id_queue_pkg::XLEN
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [XLEN-1:0]            in_pc,
    input  logic [XLEN-1:0]            in_pc_plus4,
    input  logic [XLEN-1:0]            in_instr,
    output logic                       stall_if,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [XLEN-1:0]            out_pc,
    output logic [XLEN-1:0]            out_pc_plus4,
    output logic [XLEN-1:0]            out_instr,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int c_ptr_w = $clog2(DEPTH);
    localparam int c_cnt_w = c_ptr_w + 1;
    localparam logic [c_cnt_w-1:0] c_full = c_cnt_w'(DEPTH);

    logic [XLEN-1:0]    r_pc       [DEPTH];
    logic [XLEN-1:0]    r_pc_plus4 [DEPTH];
    logic [XLEN-1:0]    r_instr    [DEPTH];
    logic [c_ptr_w-1:0] r_wp;
    logic [c_ptr_w-1:0] r_rp;
    logic [c_cnt_w-1:0] r_count;

    logic w_in_ready;
    logic w_out_valid;
    logic w_push;
    logic w_pop;

    // Both handshake flags come from the registered count only, so a pop in
    // the same cycle never re-opens in_ready (no full-bypass).
    assign w_in_ready  = (r_count != c_full);
    assign w_out_valid = (r_count != '0);
    assign w_push      = in_valid & w_in_ready & ~flush;
    assign w_pop       = w_out_valid & out_ready & ~flush;

    // Storage: one write enable per entry so each slot is a plain flop bank.
    // Contents are not reset; validity is tracked solely by r_count.
    for (genvar i = 0; i < DEPTH; i++) begin : g_entry
        always_ff @(posedge clk) begin
            if (w_push && (r_wp == c_ptr_w'(i))) begin
                r_pc[i]       <= in_pc;
                r_pc_plus4[i] <= in_pc_plus4;
                r_instr[i]    <= in_instr;
            end
        end
    end

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!rst || flush) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wp <= r_wp + c_ptr_w'(1);
            end
            if (w_pop) begin
                r_rp <= r_rp + c_ptr_w'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + c_cnt_w'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - c_cnt_w'(1);
            end
        end
    end

    // Show-ahead head; an empty queue presents a NOP bubble to ID.
    always_comb begin
        out_pc       = '0;
        out_pc_plus4 = '0;
        out_instr    = XLEN'(c_nop_instr);
        if (w_out_valid) begin
            out_pc       = r_pc[r_rp];
            out_pc_plus4 = r_pc_plus4[r_rp];
            out_instr    = r_instr[r_rp];
        end
    end

    assign in_ready  = w_in_ready;
    assign stall_if  = ~w_in_ready;
    assign out_valid = w_out_valid;
    assign count     = r_count;

endmodule : if_id_queue
`default_nettype wire

// File: tb/tb_if_id_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_if_id_queue
// Description : Self-checking bench for if_id_queue. The expected contents
//               of the queue are held in an SV queue of entries; accepted
//               pushes append, consumed heads are removed, flush/reset clear.
//               A monitor on the falling edge compares the DUT against it.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_if_id_queue;

    localparam int DEPTH = 4;
    localparam int XLEN  = 32;
    localparam int CW    = $clog2(DEPTH) + 1;

    typedef struct {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc4;
        logic [XLEN-1:0] instr;
    } ent_t;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            flush = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [XLEN-1:0] in_pc = '0;
    logic [XLEN-1:0] in_pc_plus4 = '0;
    logic [XLEN-1:0] in_instr = '0;
    logic            stall_if;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [XLEN-1:0] out_pc;
    logic [XLEN-1:0] out_pc_plus4;
    logic [XLEN-1:0] out_instr;
    logic [CW-1:0]   count;

    int   checks   = 0;
    int   failures = 0;
    bit   started  = 1'b0;
    ent_t exp_q[$];

    if_id_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_pc        (in_pc),
        .in_pc_plus4  (in_pc_plus4),
        .in_instr     (in_instr),
        .stall_if     (stall_if),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_pc       (out_pc),
        .out_pc_plus4 (out_pc_plus4),
        .out_instr    (out_instr),
        .count        (count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Reference model: a bounded FIFO of entries, updated at each rising edge.
    always @(posedge clk) begin
        int   n;
        bit   do_pop;
        bit   do_push;
        ent_t e;
        started = 1'b1;
        if (!rst || flush) begin
            exp_q.delete();
        end else begin
            n       = exp_q.size();
            do_pop  = out_ready && (n > 0);
            do_push = in_valid && (n < DEPTH);
            e.pc    = in_pc;
            e.pc4   = in_pc_plus4;
            e.instr = in_instr;
            if (do_pop)  void'(exp_q.pop_front());
            if (do_push) exp_q.push_back(e);
        end
    end

    // Monitor: compares DUT outputs with the model away from the active edge.
    always @(negedge clk) begin
        int n;
        if (started) begin
            n = exp_q.size();
            check("count",     64'(count),     64'(n));
            check("in_ready",  64'(in_ready),  64'(n < DEPTH));
            check("stall_if",  64'(stall_if),  64'(n >= DEPTH));
            check("out_valid", 64'(out_valid), 64'(n > 0));
            if (n > 0) begin
                check("out_pc",       64'(out_pc),       64'(exp_q[0].pc));
                check("out_pc_plus4", 64'(out_pc_plus4), 64'(exp_q[0].pc4));
                check("out_instr",    64'(out_instr),    64'(exp_q[0].instr));
            end else begin
                check("bubble_pc",       64'(out_pc),       64'h0);
                check("bubble_pc_plus4", 64'(out_pc_plus4), 64'h0);
                check("bubble_instr",    64'(out_instr),    64'h13);
            end
        end
    end

    task automatic step(input logic r, input logic f, input logic v,
                        input logic [XLEN-1:0] pc, input logic ordy);
        rst         = r;
        flush       = f;
        in_valid    = v;
        in_pc       = pc;
        in_pc_plus4 = pc + 32'd4;
        in_instr    = $urandom;
        out_ready   = ordy;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset held two cycles with IF presenting an entry
        step(1'b0, 1'b0, 1'b1, 32'h40, 1'b0);
        step(1'b0, 1'b0, 1'b1, 32'h40, 1'b0);
        step(1'b1, 1'b0, 1'b0, 32'h0,  1'b0);

        // Fill to full, refused fifth push, then drain
        for (int k = 0; k < 4; k++) step(1'b1, 1'b0, 1'b1, 32'(4 * k), 1'b0);
        step(1'b1, 1'b0, 1'b1, 32'h10, 1'b0);
        for (int k = 0; k < 5; k++) step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);

        // Streaming across pointer wrap, occupancy held at one
        for (int k = 0; k < 10; k++) step(1'b1, 1'b0, 1'b1, 32'h100 + 32'(4 * k), 1'b1);
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);

        // Flush with three queued and a coinciding push
        for (int k = 0; k < 3; k++) step(1'b1, 1'b0, 1'b1, 32'h10 + 32'(4 * k), 1'b0);
        step(1'b1, 1'b1, 1'b1, 32'h20, 1'b1);
        step(1'b1, 1'b0, 1'b1, 32'h80, 1'b0);
        step(1'b1, 1'b0, 1'b0, 32'h0,  1'b1);
        step(1'b1, 1'b0, 1'b0, 32'h0,  1'b1);

        // Full with simultaneous pop and push attempt
        for (int k = 0; k < 4; k++) step(1'b1, 1'b0, 1'b1, 32'h200 + 32'(4 * k), 1'b0);
        step(1'b1, 1'b0, 1'b1, 32'h50, 1'b1);
        step(1'b1, 1'b0, 1'b1, 32'h50, 1'b0);
        for (int k = 0; k < 5; k++) step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);

        // Reset mid-operation with a coinciding push
        step(1'b1, 1'b0, 1'b1, 32'h300, 1'b0);
        step(1'b1, 1'b0, 1'b1, 32'h304, 1'b0);
        step(1'b0, 1'b0, 1'b1, 32'h90,  1'b1);
        step(1'b1, 1'b0, 1'b0, 32'h0,   1'b0);

        // Randomized traffic with occasional flush and reset
        for (int k = 0; k < 1500; k++) begin
            step(($urandom_range(0, 99) != 0),
                 ($urandom_range(0, 19) == 0),
                 ($urandom_range(0, 9) < 7),
                 {$urandom_range(0, 32'h3FFF), 2'b00},
                 ($urandom_range(0, 9) < 6));
        end
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);

        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_if_id_queue
`default_nettype wire

// File: doc/if_id_queue.md
# if_id_queue

Instruction queue between the IF stage and the ID stage of the 5-stage pipeline. It buffers up to DEPTH fetched entries of {pc, pc_plus4, instr} from IF and presents them in order to ID over a valid/ready handshake. It decouples ID stalls from the fetch PC through `stall_if`, and discards all wrong-path entries in one cycle when a branch or jump redirect (`flush`) is asserted.

## Interface
- DEPTH, 4, number of entries; power of two, ≥2
- XLEN, 32, width of pc and instruction fields
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-low (0 = reset)
- flush  in  1  redirect taken (pc_src of the taken branch/jump); empties the queue
- in_valid  in  1  IF presents a fetched entry
- in_ready  out  1  queue can accept an entry; = (count != DEPTH)
- in_pc  in  XLEN  pc of fetched instruction
- in_pc_plus4  in  XLEN  pc + 4
- in_instr  in  XLEN  fetched instruction word
- stall_if  out  1  = ~in_ready; drives the IF stall input
- out_valid  out  1  head entry valid for ID
- out_ready  in  1  ID consumes the head this cycle
- out_pc, out_pc_plus4, out_instr  out  XLEN each  head entry fields
- count  out  $clog2(DEPTH)+1  current occupancy

## Operation
- push = in_valid & in_ready & ~flush; pop = out_valid & out_ready & ~flush.
- Storage: DEPTH-entry array, write pointer wp and read pointer rp, each $clog2(DEPTH) bits, wrapping modulo DEPTH. A separate count register distinguishes full from empty.
- Push: write the entry at wp, then wp+1.
- Pop: rp+1.
- count update: +1 on push only, −1 on pop only, unchanged when both push and pop occur or when neither does.
- When full: in_ready=0, so no push. A pop in the same cycle does not re-enable in_ready until the next cycle; there is no full-bypass.
- When empty: out_valid=0. No empty-bypass; a pushed entry appears on the next cycle.
- Head outputs are read combinationally from entry[rp] (show-ahead).
- When out_valid=0, outputs are forced to out_instr=NOP (32'h00000013), out_pc=0, out_pc_plus4=0. ID therefore decodes a bubble.
- flush (highest priority below reset): wp=rp=0, count=0. A coinciding in_valid entry is dropped and a coinciding pop is ignored. Storage contents need not be cleared.
- Reset (rst=0 at an edge): wp=rp=0, count=0; overrides flush and in-flight push/pop. Reset mid-operation discards all entries.
- in_* must be held stable while in_valid & ~in_ready. The queue does not check this.

## Timing
- Reset values of outputs: in_ready=1, stall_if=0, out_valid=0, out_instr=32'h00000013, out_pc=0, out_pc_plus4=0, count=0.
- Latency: push at edge N means out_valid=1 with that entry in the cycle after edge N. Minimum IF→ID latency is 1 cycle.
- Throughput: 1 entry/cycle in steady state with 1 ≤ count < DEPTH.
- flush asserted at edge N: out_valid=0 and in_ready=1 from the cycle after edge N. The first correct-path entry can be pushed at edge N+1.
- stall_if and in_ready depend only on registered count; there is no combinational path from out_ready.
- out_* depend on registered state only; there is no combinational path from in_*.

## Structure
- Shared pipeline package holds XLEN, the NOP constant 32'h00000013, and a packed fetch_entry_t {pc, pc_plus4, instr}. The same typedef is used by the ID stage.
- Single module, no sub-module: storage array, pointers and count are inline. The array is written with a plain per-entry enable so it maps to flops.

## Test plan
- Reset: hold rst=0 for 2 cycles with in_valid=1, then release → count=0, out_valid=0, out_instr=32'h00000013, in_ready=1.
- Fill/drain: out_ready=0, push pc=0x0,0x4,0x8,0xC → count=4, in_ready=0, stall_if=1. A 5th push is refused. Then out_ready=1 → out_pc 0x0,0x4,0x8,0xC on consecutive cycles, then out_valid=0.
- Wrap-around: continuous push/pop at 1/cycle for 10 entries (pc 0x100..0x124) with count held at 1 → out_pc sequence exact and in order, no loss across pointer wrap.
- Flush: with 3 entries queued and in_valid=1 (pc=0x20) in the flush cycle → next cycle count=0, out_valid=0. Entry 0x20 never appears. The next push (pc=0x80) appears one cycle later.
- Full simultaneous: count=4, out_ready=1 and in_valid=1 in the same cycle → pop occurs, push refused, count=3 after the edge, in_ready=1 the cycle after.
- Reset mid-operation: count=2, assert rst=0 together with flush=0 and push → count=0, all outputs at reset values next cycle.
